alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Execute-stage ALU of the single-cycle datapath, consuming operand A from the register file and operand B from the ALU-source mux output. Standard integer ops complete combinationally in the same cycle. Unsigned multiply, divide and remainder run on an iterative 32-step engine that raises `stall` to freeze the PC and register-file write until the result is ready.

## Interface
- `WIDTH`, 32, operand/result width; the iteration count equals `WIDTH`.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; clears FSM, counter, internal registers
- `read_data1`  in  WIDTH  operand A (register file ReadData1)
- `alusrc_result`  in  WIDTH  operand B (ALU-source mux output)
- `alu_control`  in  4  operation select
- `start`  in  1  instruction valid; qualifies launch of a mul/div op
- `alu_result`  out  WIDTH  result
- `zero`  out  1  `alu_result == 0`
- `stall`  out  1  hold PC and suppress register write this cycle
- `done`  out  1  one-cycle pulse when a mul/div result is presented

## Operation
- Combinational codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed; result 1 or 0). Shift amount is B[4:0]. ADD/SUB wrap modulo 2^WIDTH with no flags.
- Iterative codes: 1000 MUL (low WIDTH bits of A*B), 1001 MULHU (high WIDTH bits, unsigned), 1010 DIVU, 1011 REMU.
- Codes 1100–1111 give result 0, do not stall, and are not iterative.
- FSM states:
  - IDLE: `alu_result` is the combinational function. An iterative op with `start`=1 gives `stall`=1 and `alu_result`=0. At the clock edge the block latches A, B and the op, clears the counter, and moves to BUSY.
  - BUSY: one shift-add step (multiply) or one restoring-division step per cycle. `stall`=1, `alu_result`=0. Move to DONE when the counter reaches WIDTH-1.
  - DONE: `alu_result` is the latched result, `stall`=0, `done`=1. Return to IDLE unconditionally. `start` is ignored here, so the still-presented instruction does not relaunch.
- Divide by zero (natural restoring-division outcome): DIVU = all ones, REMU = A. It takes the same cycle count as any other divide, and no exception is raised.
- Operands are latched at launch. Input changes during BUSY have no effect.
- An iterative code with `start`=0 in IDLE gives `alu_result`=0, `stall`=0, and no launch.

## Timing
- Combinational ops: 0-cycle latency. `alu_result` and `zero` are valid in the same cycle as the inputs.
- Iterative op: `stall` is high for the launch cycle plus WIDTH BUSY cycles (33 cycles total). DONE is cycle 34, and the PC advances at the end of it.
- `done` is high for exactly one cycle per launch.
- While `reset` is high: state IDLE, `stall`=0, `done`=0, `alu_result` follows the combinational path, and iterative codes give 0.
- Reset asserted mid-BUSY or mid-DONE aborts immediately. Partial results are discarded, and `stall` drops the same cycle (asynchronously).

## Configuration
- `ALU_MULDIV_EN` defined: iterative engine, FSM and counter are built as described above.
- `ALU_MULDIV_EN` undefined: codes 1000–1011 return 0 combinationally. `stall` and `done` are tied to 0, and no sequential logic is built.

## Test plan
- Combinational ops:
  - A=5, B=3, code 0010 → `alu_result`=8, `zero`=0, `stall`=0 in the same cycle.
  - A=3, B=3, code 0110 → 0, `zero`=1.
  - A=0xFFFFFFFF, B=1, code 0111 → 1.
- Multiply: A=7, B=6, code 1000, `start`=1 → `stall` high 33 cycles, then `done`=1 with `alu_result`=42. MULHU with A=B=0xFFFFFFFF → 0xFFFFFFFE.
- Divide: A=100, B=7 → DIVU 14 and REMU 2, each on its `done` cycle. A=100, B=0 → DIVU 0xFFFFFFFF, REMU 100.
- No relaunch: hold the instruction and `start` high through DONE → returns to IDLE after exactly one `done` pulse. A new op issued the next cycle launches normally.
- Reset mid-operation: assert `reset` at BUSY cycle 10 → `stall`=0 and `done`=0 immediately. After release, a fresh MUL 3*4 yields 12.
- Input isolation: change `read_data1` and `alusrc_result` during BUSY → result still reflects the launch-time operands.

Source files
------------

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle integer ops plus an optional iterative unsigned
// mul/div engine (enabled with `define ALU_MULDIV_EN) that stalls the pipeline while busy.
module alu_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] read_data1,
   input  logic [WIDTH-1:0] alusrc_result,
   input  logic [3:0]       alu_control,
   input  logic             start,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero,
   output logic             stall,
   output logic             done
);
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0]   comb_result;
   logic [SHAMT_W-1:0] shamt;
   logic               is_iter;

   assign shamt   = alusrc_result[SHAMT_W-1:0];
   assign is_iter = (alu_control[3:2] == 2'b10);

   // Single-cycle ops; iterative and reserved codes read as zero here
   always_comb begin
      comb_result = '0;
      case (alu_control)
         4'b0000: comb_result = read_data1 & alusrc_result;
         4'b0001: comb_result = read_data1 | alusrc_result;
         4'b0010: comb_result = read_data1 + alusrc_result;
         4'b0011: comb_result = read_data1 ^ alusrc_result;
         4'b0100: comb_result = read_data1 << shamt;
         4'b0101: comb_result = read_data1 >> shamt;
         4'b0110: comb_result = read_data1 - alusrc_result;
         4'b0111: comb_result = ($signed(read_data1) < $signed(alusrc_result)) ? WIDTH'(1) : '0;
         default: comb_result = '0;
      endcase
   end

`ifdef ALU_MULDIV_EN
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;

   // hi/lo hold product halves for multiply, remainder/quotient for divide
   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
   assign div_shift = {hi_q, lo_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= '0;
         opnd_q <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && is_iter) begin
                  op_q   <= alu_control[1:0];
                  cnt    <= '0;
                  hi_q   <= '0;
                  lo_q   <= alu_control[1] ? read_data1 : alusrc_result;
                  opnd_q <= alu_control[1] ? alusrc_result : read_data1;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (!op_q[1]) begin
                  hi_q <= mul_sum[WIDTH:1];
                  lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
               end else if (div_diff[WIDTH]) begin
                  hi_q <= div_shift[WIDTH-1:0];
                  lo_q <= {lo_q[WIDTH-2:0], 1'b0};
               end else begin
                  hi_q <= div_diff[WIDTH-1:0];
                  lo_q <= {lo_q[WIDTH-2:0], 1'b1};
               end
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               // start ignored so the still-presented instruction cannot relaunch
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Reset gating keeps stall low during reset even with a launchable op presented
   always_comb begin
      alu_result = comb_result;
      stall      = 1'b0;
      done       = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: stall = start & is_iter;
            BUSY: begin
               alu_result = '0;
               stall      = 1'b1;
            end
            DONE: begin
               alu_result = op_q[0] ? hi_q : lo_q;
               done       = 1'b1;
            end
            default: ;
         endcase
      end
   end
`else
   logic unused_ok;

   assign unused_ok  = &{1'b0, clk, reset, start};
   assign alu_result = comb_result;
   assign stall      = 1'b0;
   assign done       = 1'b0;
`endif

   assign zero = (alu_result == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized self-checking bench for alu_muldiv against an arithmetic reference model;
// iterative tests run only when ALU_MULDIV_EN is defined.
module tb_alu_muldiv;
   localparam int unsigned WIDTH = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [WIDTH-1:0]  read_data1;
   logic [WIDTH-1:0]  alusrc_result;
   logic [3:0]        alu_control;
   logic              start;
   logic [WIDTH-1:0]  alu_result;
   logic              zero;
   logic              stall;
   logic              done;

   int vectors     = 0;
   int miscompares = 0;

   alu_muldiv #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .read_data1   (read_data1),
      .alusrc_result(alusrc_result),
      .alu_control  (alu_control),
      .start        (start),
      .alu_result   (alu_result),
      .zero         (zero),
      .stall        (stall),
      .done         (done)
   );

   always #5 clk = ~clk;

   // Reference results from plain arithmetic
   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] code);
      longint unsigned p;
      p = longint'(a) * longint'(b);
      case (code)
         4'd0:  return a & b;
         4'd1:  return a | b;
         4'd2:  return a + b;
         4'd3:  return a ^ b;
         4'd4:  return a << (b % 32);
         4'd5:  return a >> (b % 32);
         4'd6:  return a - b;
         4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd8:  return p[31:0];
         4'd9:  return p[63:32];
         4'd10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'd11: return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic comb_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] code, input logic st);
      logic [31:0] exp;
      exp = (code >= 4'd8) ? 32'd0 : ref_alu(a, b, code);
      @(posedge clk); #1;
      read_data1 = a; alusrc_result = b; alu_control = code; start = st;
      #3;
      vectors++;
      if ({stall, done, zero, alu_result} !== {2'b00, exp == 32'd0, exp}) begin
         miscompares++;
         $display("FAIL %s code=%0d a=%h b=%h: got stall=%0b done=%0b zero=%0b res=%h, want stall=0 done=0 zero=%0b res=%h",
                  name, code, a, b, stall, done, zero, alu_result, exp == 32'd0, exp);
      end
   endtask

   task automatic test_reset;
      #2;
      vectors++;
      if ({stall, done, zero, alu_result} !== {3'b001, 32'd0}) begin
         miscompares++;
         $display("FAIL reset_state: got stall=%0b done=%0b zero=%0b res=%h, want 0 0 1 0",
                  stall, done, zero, alu_result);
      end
      read_data1 = 32'd9; alusrc_result = 32'd4; alu_control = 4'b1000; start = 1'b1;
      #1;
      vectors++;
      if ({stall, done, alu_result} !== {2'b00, 32'd0}) begin
         miscompares++;
         $display("FAIL reset_iter: got stall=%0b done=%0b res=%h, want 0 0 0", stall, done, alu_result);
      end
      alu_control = 4'b0010; read_data1 = 32'd5; alusrc_result = 32'd3;
      #1;
      vectors++;
      if ({stall, alu_result} !== {1'b0, 32'd8}) begin
         miscompares++;
         $display("FAIL reset_comb: got stall=%0b res=%h, want 0 8", stall, alu_result);
      end
      @(posedge clk); #1;
      start = 1'b0; reset = 1'b0;
   endtask

   task automatic test_comb;
      comb_vec("add", 32'd5, 32'd3, 4'b0010, 1'b0);
      comb_vec("sub_zero", 32'd3, 32'd3, 4'b0110, 1'b0);
      comb_vec("slt_neg", 32'hFFFF_FFFF, 32'd1, 4'b0111, 1'b0);
      comb_vec("slt_pos", 32'd1, 32'hFFFF_FFFF, 4'b0111, 1'b1);
      comb_vec("add_wrap", 32'hFFFF_FFFF, 32'd2, 4'b0010, 1'b0);
      comb_vec("sll", 32'h0000_00F1, 32'h0000_0124, 4'b0100, 1'b0);
      comb_vec("srl", 32'h8000_0000, 32'd31, 4'b0101, 1'b0);
      for (int c = 12; c < 16; c++) comb_vec("reserved", 32'hDEAD_BEEF, 32'd7, 4'(c), 1'b1);
      for (int i = 0; i < 40; i++) begin
         logic [3:0] code;
         logic       st;
         code = 4'($urandom_range(0, 15));
         st   = 1'($urandom);
`ifdef ALU_MULDIV_EN
         if (code[3:2] == 2'b10) st = 1'b0;
`endif
         comb_vec("rand_comb", $urandom, $urandom, code, st);
      end
   endtask

`ifdef ALU_MULDIV_EN
   // Launch, then check every stall cycle and the single done cycle
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] code,
                         input bit scramble);
      logic [31:0] exp;
      exp = ref_alu(a, b, code);
      @(posedge clk); #1;
      read_data1 = a; alusrc_result = b; alu_control = code; start = 1'b1;
      #3;
      vectors++;
      if ({stall, done, alu_result} !== {2'b10, 32'd0}) begin
         miscompares++;
         $display("FAIL launch code=%0d: got stall=%0b done=%0b res=%h, want 1 0 0",
                  code, stall, done, alu_result);
      end
      for (int i = 0; i < WIDTH; i++) begin
         @(posedge clk); #1;
         if (scramble) begin
            read_data1 = $urandom; alusrc_result = $urandom;
         end
         #3;
         vectors++;
         if ({stall, done, alu_result} !== {2'b10, 32'd0}) begin
            miscompares++;
            $display("FAIL busy%0d code=%0d: got stall=%0b done=%0b res=%h, want 1 0 0",
                     i, code, stall, done, alu_result);
         end
      end
      @(posedge clk); #4;
      vectors++;
      if ({stall, done, zero, alu_result} !== {2'b01, exp == 32'd0, exp}) begin
         miscompares++;
         $display("FAIL result code=%0d a=%h b=%h: got stall=%0b done=%0b zero=%0b res=%h, want 0 1 %0b %h",
                  code, a, b, stall, done, zero, alu_result, exp == 32'd0, exp);
      end
   endtask

   task automatic test_mul;
      run_op(32'd7, 32'd6, 4'b1000, 1'b0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1001, 1'b0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, 1'b0);
   endtask

   task automatic test_div;
      run_op(32'd100, 32'd7, 4'b1010, 1'b0);
      run_op(32'd100, 32'd7, 4'b1011, 1'b0);
      run_op(32'd100, 32'd0, 4'b1010, 1'b0);
      run_op(32'd100, 32'd0, 4'b1011, 1'b0);
   endtask

   task automatic test_no_relaunch;
      run_op(32'd20, 32'd3, 4'b1010, 1'b0);
      comb_vec("after_done", 32'd1, 32'd2, 4'b0010, 1'b1);
      comb_vec("idle_hold", 32'd1, 32'd2, 4'b0010, 1'b1);
      comb_vec("iter_nostart", 32'd9, 32'd9, 4'b1000, 1'b0);
   endtask

   task automatic test_back_to_back;
      run_op(32'd12, 32'd12, 4'b1000, 1'b0);
      run_op(32'hFFFF_FFF0, 32'd16, 4'b1011, 1'b0);
      run_op(32'h1234_5678, 32'h9ABC_DEF0, 4'b1001, 1'b0);
   endtask

   task automatic test_isolation;
      run_op(32'd1000, 32'd33, 4'b1010, 1'b1);
      run_op(32'hCAFE_F00D, 32'h0BAD_BEEF, 4'b1000, 1'b1);
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1;
      read_data1 = 32'd123; alusrc_result = 32'd456; alu_control = 4'b1000; start = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if ({stall, done, alu_result} !== {2'b00, 32'd0}) begin
         miscompares++;
         $display("FAIL reset_mid: got stall=%0b done=%0b res=%h, want 0 0 0", stall, done, alu_result);
      end
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      comb_vec("post_reset_idle", 32'd4, 32'd4, 4'b0110, 1'b0);
      run_op(32'd3, 32'd4, 4'b1000, 1'b0);
   endtask

   task automatic test_random_iter;
      for (int i = 0; i < 8; i++) begin
         logic [31:0] b;
         b = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         run_op($urandom, b, 4'($urandom_range(8, 11)), 1'($urandom));
      end
   endtask
`else
   task automatic test_iter_disabled;
      for (int c = 8; c < 12; c++) begin
         comb_vec("iter_disabled", 32'd100, 32'd7, 4'(c), 1'b1);
         comb_vec("iter_disabled_hold", 32'd100, 32'd7, 4'(c), 1'b1);
      end
   endtask
`endif

   initial begin
      reset = 1'b1; start = 1'b0;
      read_data1 = '0; alusrc_result = '0; alu_control = '0;
      test_reset;
      test_comb;
`ifdef ALU_MULDIV_EN
      test_mul;
      test_div;
      test_no_relaunch;
      test_back_to_back;
      test_isolation;
      test_reset_mid;
      test_random_iter;
`else
      test_iter_disabled;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
